lsu_mem_initiator: RTL

- Load/store initiator sitting between the CPU execute stage and Data_Mem.
- Converts byte-addressed load/store requests (byte/half/word, signed/unsigned) into Data_Mem word accesses.
- Sub-word stores are done as read-modify-write; loads are extracted and extended.
- Uses a valid/ready request handshake and a one-cycle response pulse so the pipeline can stall on it.

---
 rtl/lsu_mem_initiator.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - load/store initiator converting byte requests into Data_Mem word accesses
module lsu_mem_initiator #(
  parameter int MEM_WORDS  = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  output logic [31:0]           mem_Address,
  output logic [31:0]           mem_WriteData,
  output logic                  mem_WriteEnable,
  output logic                  mem_MemRead,
  input  logic [31:0]           mem_ReadData
);

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  write_q;
  logic [31:0]           wdata_q;

  logic                  accept;
  logic                  req_fault;
  logic [ADDR_WIDTH-1:0] req_word;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [31:0]           load_ext;
  logic [31:0]           lane_mask;
  logic [31:0]           merged;
  logic [4:0]            lane_shift;

  assign req_ready       = (state == IDLE);
  assign accept          = req_valid & req_ready;
  assign req_word        = req_addr >> 2;
  assign req_fault       = (req_size == 2'b11) ||
                           ((req_size == 2'b01) && req_addr[0]) ||
                           ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                           (req_word >= ADDR_WIDTH'(MEM_WORDS));

  // Strobes and address come only from registered state so an async reset kills them at once
  assign mem_MemRead     = (state == RD);
  assign mem_WriteEnable = (state == WR);
  assign mem_Address     = 32'(addr_q >> 2);

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: faults never leave IDLE, aligned word stores skip the read
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !req_fault) begin
          if (req_write && (req_size == 2'b10)) state_next = WR;
          else                                  state_next = RD;
        end
      end
      RD:      state_next = CAP;
      CAP:     state_next = write_q ? WR : IDLE;
      WR:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Little-endian lane extraction, extension and store merge on the captured read word
  always_comb begin
    lane_shift = {addr_q[1:0], 3'b000};
    lane_byte  = 8'h00;
    case (addr_q[1:0])
      2'd0:    lane_byte = mem_ReadData[7:0];
      2'd1:    lane_byte = mem_ReadData[15:8];
      2'd2:    lane_byte = mem_ReadData[23:16];
      default: lane_byte = mem_ReadData[31:24];
    endcase
    lane_half = addr_q[1] ? mem_ReadData[31:16] : mem_ReadData[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = {{16{~uns_q & lane_half[15]}}, lane_half};
      default: load_ext = mem_ReadData;
    endcase
    lane_mask = (size_q == 2'b00) ? (32'h0000_00FF << lane_shift) : (32'h0000_FFFF << lane_shift);
    merged    = (mem_ReadData & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
  end

  // Request capture, write-word build and one-cycle response generation
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      addr_q        <= '0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      write_q       <= 1'b0;
      wdata_q       <= 32'h0;
      mem_WriteData <= 32'h0;
      resp_valid    <= 1'b0;
      resp_fault    <= 1'b0;
      resp_rdata    <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        write_q <= req_write;
        wdata_q <= req_wdata;
        if (req_fault) begin
          resp_valid <= 1'b1;
          resp_fault <= 1'b1;
          resp_rdata <= 32'h0;
        end else if (req_write && (req_size == 2'b10)) begin
          mem_WriteData <= req_wdata;
        end
      end
      case (state)
        CAP: begin
          if (write_q) begin
            mem_WriteData <= merged;
          end else begin
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= load_ext;
          end
        end
        WR: begin
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_rdata <= 32'h0;
        end
        default: ;
      endcase
    end
  end

endmodule
